// File: rtl/wb_obi_bridge.sv
// wb_obi_bridge: Wishbone-classic slave to OBI master bridge with response timeout.
// A timed-out OBI transfer is still driven to completion and its response discarded.
module wb_obi_bridge #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = '0,
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic                wb_clk_i,
    input  logic                soc_rst_ni,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_wdata_i,
    output logic [DATA_W-1:0]   wb_rdata_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic                obi_we_o,
    output logic [DATA_W/8-1:0] obi_be_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i
);
    localparam int CNT_W = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, ERR, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                granted_q, granted_d;
    logic                abort_q, abort_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                timeout;

    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        granted_d = granted_q;
        abort_d   = abort_q;
        req_d     = req_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                    addr_d    = wb_addr_i + ADDR_OFFSET;
                    we_d      = wb_we_i;
                    be_d      = wb_sel_i;
                    wdata_d   = wb_wdata_i;
                    req_d     = 1'b1;
                    cnt_d     = '0;
                    granted_d = 1'b0;
                    abort_d   = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ, WAIT: begin
                abort_d = abort_q | ~wb_cyc_i;
                if (TIMEOUT_CYC != 0) cnt_d = cnt_q + 1'b1;
                if (state_q == REQ && obi_gnt_i) begin
                    req_d     = 1'b0;
                    granted_d = 1'b1;
                end
                // a response arriving on the expiry cycle takes priority over the timeout
                if (state_q == WAIT && obi_rvalid_i) begin
                    rdata_d = abort_d ? rdata_q : obi_rdata_i;
                    ack_d   = ~abort_d;
                    state_d = abort_d ? IDLE : ACK;
                end else if (timeout) begin
                    err_d   = ~abort_d;
                    state_d = abort_d ? DRAIN : ERR;
                end else if (state_q == REQ && obi_gnt_i) begin
                    state_d = WAIT;
                end
            end
            ACK: state_d = IDLE;
            ERR, DRAIN: begin
                if (req_q && obi_gnt_i) begin
                    req_d     = 1'b0;
                    granted_d = 1'b1;
                end
                state_d = (granted_q && obi_rvalid_i) ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge soc_rst_ni) begin
        if (!soc_rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            granted_q <= 1'b0;
            abort_q   <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            granted_q <= granted_d;
            abort_q   <= abort_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign wb_rdata_o  = rdata_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign obi_req_o   = req_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = wdata_q;
endmodule

// File: tb/tb_wb_obi_bridge.sv
// tb_wb_obi_bridge: directed checks of the Wishbone-to-OBI bridge with a scripted OBI target.
module tb_wb_obi_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] wb_rdata;
    logic        ack, err;
    logic        req, gnt = 1'b0;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [31:0] OFS = 32'h2000_0000;

    wb_obi_bridge #(.ADDR_W(32), .DATA_W(32), .ADDR_OFFSET(OFS), .TIMEOUT_CYC(8)) dut (
        .wb_clk_i(clk), .soc_rst_ni(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
        .wb_addr_i(addr), .wb_wdata_i(wdata), .wb_rdata_o(wb_rdata),
        .wb_ack_o(ack), .wb_err_o(err),
        .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
        .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(rvalid), .obi_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] rdat, input string tag);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; addr = a; wdata = wd;
        step;
        for (int i = 0; i <= gd; i++) begin
            chk({tag, "_req"}, req, 1);
            chk({tag, "_addr"}, obi_addr, a + OFS);
            chk({tag, "_we"}, obi_we, w);
            chk({tag, "_be"}, obi_be, s);
            chk({tag, "_wdata"}, obi_wdata, wd);
            if (i == gd) gnt = 1'b1;
            step;
        end
        gnt = 1'b0;
        chk({tag, "_req_drop"}, req, 0);
        repeat (rd) begin
            chk({tag, "_early_ack"}, ack, 0);
            step;
        end
        chk({tag, "_early_ack"}, ack, 0);
        rvalid = 1'b1; rdata = rdat;
        step;
        rvalid = 1'b0; cyc = 1'b0; stb = 1'b0;
        chk({tag, "_ack"}, ack, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rdata"}, wb_rdata, rdat);
        step;
        chk({tag, "_ack_pulse"}, ack, 0);
        chk({tag, "_idle_req"}, req, 0);
    endtask

    int gd_t[10] = '{0, 1, 2, 5, 3, 0, 4, 1, 2, 5};
    int rd_t[10] = '{0, 2, 1, 2, 4, 5, 0, 3, 3, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", obi_addr, 0);
        chk("rst_rdata", wb_rdata, 0);
        rst_n = 1'b1;
        step;

        wb_xfer(1'b0, 32'h100, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF, "rd0");
        wb_xfer(1'b1, 32'h40, 4'b0011, 32'h1234_5678, 4, 1, 32'h0, "wr");

        // timeout: target never grants
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; addr = 32'h80;
        step;
        chk("to_req", req, 1);
        for (int i = 0; i < 8; i++) begin
            step;
            chk("to_no_err", err, 0);
        end
        step;
        chk("to_err", err, 1);
        chk("to_req_held", req, 1);
        chk("to_no_ack", ack, 0);
        cyc = 1'b0; stb = 1'b0;
        step;
        chk("to_err_pulse", err, 0);
        chk("to_drain_req", req, 1);
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        chk("to_drain_gnt", req, 0);
        step;
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        step;
        rvalid = 1'b0;
        chk("to_drain_ack", ack, 0);
        chk("to_drain_err", err, 0);
        step;
        chk("to_drain_ack2", ack, 0);
        wb_xfer(1'b0, 32'h84, 4'hF, 32'h0, 1, 1, 32'h0BAD_F00D, "post_to");

        // Wishbone abort during WAIT
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h200;
        step;
        gnt = 1'b1;
        step;
        gnt = 1'b0; cyc = 1'b0; stb = 1'b0;
        step;
        rvalid = 1'b1; rdata = 32'h0000_0BAD;
        step;
        rvalid = 1'b0;
        chk("ab_no_ack", ack, 0);
        chk("ab_no_err", err, 0);
        step;
        chk("ab_no_ack2", ack, 0);
        wb_xfer(1'b0, 32'h204, 4'hF, 32'h0, 0, 0, 32'hCAFE_0001, "post_ab");

        for (int i = 0; i < 10; i++)
            wb_xfer(1'b0, 32'h1000 + 32'(i * 4), 4'hF, 32'h0, gd_t[i], rd_t[i],
                    32'hA000_0000 + 32'(i) * 32'h1111, $sformatf("b2b%0d", i));

        // asynchronous reset while waiting for a response
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hC; addr = 32'h300; wdata = 32'h7777_0000;
        step;
        gnt = 1'b1;
        step;
        gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", req, 0);
        chk("ar_addr", obi_addr, 0);
        chk("ar_we", obi_we, 0);
        chk("ar_be", obi_be, 0);
        chk("ar_wdata", obi_wdata, 0);
        chk("ar_ack", ack, 0);
        cyc = 1'b0; stb = 1'b0;
        step;
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h1357_9BDF;
        step;
        rvalid = 1'b0;
        chk("ar_stray_ack", ack, 0);
        step;
        chk("ar_stray_ack2", ack, 0);
        chk("ar_stray_req", req, 0);
        wb_xfer(1'b0, 32'h400, 4'hF, 32'h0, 2, 2, 32'h2468_ACE0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
